// File: rtl/match_logger.sv
// Timestamped match logger: counts rising edges of F and queues their timestamps in a 4-deep show-ahead FIFO.
// Optional sticky dropped-event flag built when MATCH_LOGGER_OVERFLOW_EN is defined.
module match_logger (
  input  logic        clock,
  input  logic        reset,
  input  logic        F,
  input  logic        enable,
  input  logic        clr,
  input  logic        rd_en,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic [7:0]  count,
  output logic        full,
  output logic        empty
`ifdef MATCH_LOGGER_OVERFLOW_EN
  ,
  output logic        overflow
`endif
);

  logic [15:0] r_ts;
  logic        r_f_q;
  logic [7:0]  r_count;
  logic [15:0] r_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_occ;

  logic w_full;
  logic w_empty;
  logic w_event;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_occ == 3'd4);
  assign w_empty = (r_occ == 3'd0);

  // clr masks event and pop so it wins over every other update on the same edge
  assign w_event = F & ~r_f_q & enable & ~clr;
  assign w_pop   = rd_en & ~w_empty & ~clr;
  // A full FIFO still accepts the event when the head is leaving on the same edge
  assign w_push  = w_event & (~w_full | w_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_f_q <= 1'b0;
    end else begin
      r_f_q <= F;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ts <= '0;
    end else if (clr) begin
      r_ts <= '0;
    end else if (enable) begin
      r_ts <= r_ts + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (w_event && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= r_ts;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 3'd1;
        2'b01:   r_occ <= r_occ - 3'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef MATCH_LOGGER_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_overflow <= 1'b0;
    end else if (w_event && !w_push) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`endif

  assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign rd_valid = ~w_empty;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule
